// File: rtl/tx_link_ctrl.sv
// tx_link_ctrl: transmit link controller for a JESD204-style serial lane.
// Sequences code-group synchronisation (K28.5 stream), a four-multiframe
// initial lane alignment sequence carrying the link configuration, and
// then user data with end-of-frame / end-of-multiframe character
// replacement. All octets go to an 8b10b encoder downstream.
module tx_link_ctrl #(
  parameter int F = 1,   // octets per frame, 1..8
  parameter int K = 32   // frames per multiframe, 17..32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_sync_n,
  input  logic [7:0]   i_data,
  input  logic         i_vld,
  input  logic [111:0] i_cfg,
  output logic         o_ready,
  output logic [7:0]   o_data,
  output logic         o_vld,
  output logic         o_k,
  output logic [1:0]   o_state,
  output logic         o_underflow
);

  // Octets per multiframe; the LMFC counter runs 0..FK-1.
  localparam int FK = F * K;

  // Reject illegal framing at elaboration time.
  generate
    if ((F < 1) || (F > 8) || (K < 17) || (K > 32) || (FK < 17) || (FK > 256)) begin : g_bad_params
      $error("tx_link_ctrl: illegal F/K combination");
    end
  endgenerate

  localparam logic [7:0] LMFC_LAST = 8'(FK - 1);
  localparam logic [2:0] FPOS_LAST = 3'(F - 1);

  // Control characters used on the lane.
  localparam logic [7:0] K28_0 = 8'h1C;  // ILAS multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // multiframe end / ILAS end
  localparam logic [7:0] K28_4 = 8'h9C;  // configuration follows
  localparam logic [7:0] K28_5 = 8'hBC;  // code-group sync
  localparam logic [7:0] K28_7 = 8'hFC;  // frame end replacement

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Synchroniser for the receiver's SYNC~ request.
  logic       r_sync_meta;
  logic       r_sync_s;

  // Local multiframe clock and position within the current frame.
  logic [7:0] r_lmfc;
  logic [2:0] r_fpos;

  // Link state machine and its registered outputs.
  state_t     r_state;
  logic [1:0] r_mf;
  logic [7:0] r_data;
  logic       r_k;
  logic       r_vld;
  logic       r_uflow;

  // Last (original, unreplaced) octet of the previous frame.
  logic [7:0] r_prev_oct;
  logic       r_prev_vld;

  // Combinational octet selections.
  logic [7:0] w_cfg_oct [0:15];
  logic [3:0] w_cfg_idx;
  logic [7:0] w_ilas_oct;
  logic       w_ilas_k;
  logic       w_lmfc_last;
  logic       w_frame_last;
  logic       w_repl;

  // Split the configuration bus into octets; slots 14 and 15 are never
  // selected but keep the lookup table a power of two deep.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi = gi + 1) begin : g_cfg_oct
      if (gi < 14) begin : g_used
        assign w_cfg_oct[gi] = i_cfg[8*gi +: 8];
      end else begin : g_pad
        assign w_cfg_oct[gi] = 8'h00;
      end
    end
  endgenerate

  assign w_lmfc_last  = (r_lmfc == LMFC_LAST);
  assign w_frame_last = (r_fpos == FPOS_LAST);
  assign w_cfg_idx    = r_lmfc[3:0] - 4'd2;

  // Two-flop synchroniser; SYNC~ reads as "requesting sync" out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_sync_s    <= 1'b0;
    end else begin
      r_sync_meta <= i_sync_n;
      r_sync_s    <= r_sync_meta;
    end
  end

  // Free-running LMFC and frame-position counters; both wrap together at
  // the multiframe boundary since FK is a whole number of frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lmfc <= 8'd0;
      r_fpos <= 3'd0;
    end else begin
      if (w_lmfc_last) begin
        r_lmfc <= 8'd0;
      end else begin
        r_lmfc <= r_lmfc + 8'd1;
      end
      if (w_frame_last || w_lmfc_last) begin
        r_fpos <= 3'd0;
      end else begin
        r_fpos <= r_fpos + 3'd1;
      end
    end
  end

  // ILAS octet for the current multiframe index and LMFC position.
  always_comb begin
    w_ilas_oct = r_lmfc;
    w_ilas_k   = 1'b0;
    if (r_lmfc == 8'd0) begin
      w_ilas_oct = K28_0;
      w_ilas_k   = 1'b1;
    end else if (w_lmfc_last) begin
      w_ilas_oct = K28_3;
      w_ilas_k   = 1'b1;
    end else if ((r_mf == 2'd1) && (r_lmfc == 8'd1)) begin
      w_ilas_oct = K28_4;
      w_ilas_k   = 1'b1;
    end else if ((r_mf == 2'd1) && (r_lmfc >= 8'd2) && (r_lmfc <= 8'd15)) begin
      w_ilas_oct = w_cfg_oct[w_cfg_idx];
      w_ilas_k   = 1'b0;
    end
  end

  // A frame-final octet equal to the previous frame's final octet is
  // replaced by a control character so the receiver can track alignment.
  assign w_repl = r_prev_vld && w_frame_last && (i_data == r_prev_oct);

  // Link state machine: picks the octet for this cycle and registers it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CGS;
      r_mf       <= 2'd0;
      r_data     <= 8'h00;
      r_k        <= 1'b0;
      r_vld      <= 1'b0;
      r_uflow    <= 1'b0;
      r_prev_oct <= 8'h00;
      r_prev_vld <= 1'b0;
    end else begin
      r_vld <= 1'b1;
      case (r_state)
        ST_CGS: begin
          r_data     <= K28_5;
          r_k        <= 1'b1;
          r_prev_vld <= 1'b0;
          // Start ILAS so its first octet lands on LMFC position 0.
          if (r_sync_s && w_lmfc_last) begin
            r_state <= ST_ILAS;
            r_mf    <= 2'd0;
          end
        end

        ST_ILAS: begin
          r_data     <= w_ilas_oct;
          r_k        <= w_ilas_k;
          r_prev_vld <= 1'b0;
          if (!r_sync_s) begin
            r_state <= ST_CGS;
          end else if (w_lmfc_last) begin
            if (r_mf == 2'd3) begin
              r_state <= ST_DATA;
            end else begin
              r_mf <= r_mf + 2'd1;
            end
          end
        end

        ST_DATA: begin
          if (i_vld) begin
            if (w_repl) begin
              r_data <= w_lmfc_last ? K28_3 : K28_7;
              r_k    <= 1'b1;
            end else begin
              r_data <= i_data;
              r_k    <= 1'b0;
            end
            // Remember the original octet, never the replacement.
            if (w_frame_last) begin
              r_prev_oct <= i_data;
              r_prev_vld <= 1'b1;
            end
          end else begin
            // Starved: pad with zero and forget the frame history.
            r_data     <= 8'h00;
            r_k        <= 1'b0;
            r_uflow    <= 1'b1;
            r_prev_vld <= 1'b0;
          end
          if (!r_sync_s) begin
            r_state <= ST_CGS;
          end
        end

        default: begin
          r_state    <= ST_CGS;
          r_data     <= K28_5;
          r_k        <= 1'b1;
          r_prev_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = (r_state == ST_DATA);
  assign o_state     = r_state;
  assign o_data      = r_data;
  assign o_k         = r_k;
  assign o_vld       = r_vld;
  assign o_underflow = r_uflow;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// tb_tx_link_ctrl: randomized bench for tx_link_ctrl with a behavioural
// model that follows the link rules by octet index rather than by state
// registers. Every cycle the packed output word is compared.
module tb_tx_link_ctrl;

  localparam int F  = 1;
  localparam int K  = 32;
  localparam int FK = F * K;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_sync_n = 1'b0;
  logic [7:0]   i_data = 8'h00;
  logic         i_vld = 1'b0;
  logic [111:0] i_cfg = '0;
  logic         o_ready;
  logic [7:0]   o_data;
  logic         o_vld;
  logic         o_k;
  logic [1:0]   o_state;
  logic         o_underflow;

  tx_link_ctrl #(.F(F), .K(K)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sync_n    (i_sync_n),
    .i_data      (i_data),
    .i_vld       (i_vld),
    .i_cfg       (i_cfg),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_vld       (o_vld),
    .o_k         (o_k),
    .o_state     (o_state),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: link phase, ILAS octet index, LMFC, run of consecutive
  // valid data octets, history of recent data octets.
  int         m_state;
  int         m_n;
  int         m_lmfc;
  int         m_run;
  logic       m_sync1;
  logic       m_sync_s;
  logic       m_uflow;
  logic [7:0] m_hist [0:7];
  logic [13:0] m_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs();
    return {o_state, o_ready, o_vld, o_k, o_underflow, o_data};
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_n      = 0;
    m_lmfc   = 0;
    m_run    = 0;
    m_sync1  = 1'b0;
    m_sync_s = 1'b0;
    m_uflow  = 1'b0;
    for (int i = 0; i < 8; i++) m_hist[i] = 8'h00;
    m_exp    = '0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_step();
    int ns;
    int mf;
    int j;
    logic [7:0] d;
    logic kk;
    logic [31:0] jv;
    ns = m_state;
    d  = 8'h00;
    kk = 1'b0;
    case (m_state)
      0: begin
        d = 8'hBC; kk = 1'b1; m_run = 0;
        if (m_sync_s && (m_lmfc == FK - 1)) begin
          ns  = 1;
          m_n = 0;
        end
      end
      1: begin
        mf = m_n / FK;
        j  = m_n % FK;
        jv = j;
        if (j == 0) begin
          d = 8'h1C; kk = 1'b1;
        end else if (j == FK - 1) begin
          d = 8'h7C; kk = 1'b1;
        end else if (mf == 1 && j == 1) begin
          d = 8'h9C; kk = 1'b1;
        end else if (mf == 1 && j >= 2 && j <= 15) begin
          d = 8'((i_cfg >> (8 * (j - 2))) & 112'hFF);
        end else begin
          d = jv[7:0];
        end
        m_n++;
        m_run = 0;
        if (!m_sync_s) ns = 0;
        else if (m_n == 4 * FK) ns = 2;
      end
      default: begin
        if (i_vld) begin
          if ((m_lmfc % F == F - 1) && (m_run >= F) && (i_data == m_hist[F-1])) begin
            d  = (m_lmfc == FK - 1) ? 8'h7C : 8'hFC;
            kk = 1'b1;
          end else begin
            d = i_data;
          end
          for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = i_data;
          m_run++;
        end else begin
          m_uflow = 1'b1;
          m_run   = 0;
        end
        if (!m_sync_s) ns = 0;
      end
    endcase
    m_sync_s = m_sync1;
    m_sync1  = i_sync_n;
    m_lmfc   = (m_lmfc + 1) % FK;
    m_state  = ns;
    m_exp    = {2'(ns), (ns == 2), 1'b1, kk, m_uflow, d};
  endtask

  // Advance one cycle (inputs already set at the falling edge) and compare.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    chk(tag, 32'(outs()), 32'(m_exp));
    @(negedge clk);
  endtask

  task automatic rnd_data(input int vld_pct);
    int r;
    r = $urandom_range(0, 3);
    i_data = (r == 0) ? 8'h55 : (r == 1) ? 8'hAA : 8'($urandom);
    i_vld  = ($urandom_range(0, 99) < vld_pct);
  endtask

  task automatic run_to_data(input string tag, input int bound);
    for (int c = 0; c < bound && m_state != 2; c++) begin
      rnd_data(100);
      cyc(tag);
    end
    chk({tag, "_reached"}, 32'(o_state), 32'd2);
  endtask

  initial begin
    int drop;
    model_reset();
    i_cfg = {$urandom, $urandom, $urandom, $urandom};

    // Reset state, held across edges.
    #3;
    chk("rst_outs", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("phase reset checks=%0d", n_checks);

    // CGS with SYNC~ held low.
    for (int c = 0; c < 100; c++) begin
      rnd_data(50);
      cyc("cgs");
    end
    chk("cgs_char", 32'(o_data), 32'hBC);
    $display("phase cgs checks=%0d", n_checks);

    // Release SYNC~ at LMFC 5 and run the full ILAS.
    for (int c = 0; c < FK && m_lmfc != 5; c++) cyc("cgs_wait");
    i_sync_n = 1'b1;
    run_to_data("ilas", 8 * FK);
    $display("phase ilas checks=%0d", n_checks);

    // Constant data: replacement every octet after the first.
    i_data = 8'h55; i_vld = 1'b1;
    cyc("const_first");
    chk("const_first_data", 32'(o_data), 32'h55);
    for (int c = 0; c < 2 * FK; c++) cyc("const");
    $display("phase const checks=%0d", n_checks);

    // Incrementing data: straight pass-through.
    for (int c = 0; c < 40; c++) begin
      i_data = 8'(c + 1);
      cyc("incr");
    end
    chk("incr_pass", 32'(o_data), 32'd40);

    // One underflow cycle, then random data with sticky underflow.
    i_vld = 1'b0;
    cyc("uflow");
    chk("uflow_flag", 32'(o_underflow), 32'd1);
    for (int c = 0; c < 200; c++) begin
      rnd_data(95);
      cyc("rand_data");
    end
    $display("phase data checks=%0d", n_checks);

    // Drop SYNC~ in DATA.
    i_sync_n = 1'b0; i_vld = 1'b1;
    cyc("drop"); cyc("drop");
    chk("ready_hold", 32'(o_ready), 32'd1);
    cyc("drop");
    chk("ready_drop", 32'(o_ready), 32'd0);
    cyc("drop");
    chk("drop_cgs", 32'(o_data), 32'hBC);
    for (int c = 0; c < 10; c++) cyc("drop_cgs");
    i_cfg = {$urandom, $urandom, $urandom, $urandom};
    i_sync_n = 1'b1;
    run_to_data("reilas", 8 * FK);
    $display("phase resync checks=%0d", n_checks);

    // Random SYNC~ drops of a few cycles over mixed traffic.
    drop = 0;
    for (int c = 0; c < 1500; c++) begin
      if (drop > 0) begin
        drop--;
        i_sync_n = 1'b0;
      end else begin
        i_sync_n = 1'b1;
        if ($urandom_range(0, 299) == 0) drop = $urandom_range(1, 4);
      end
      rnd_data(95);
      cyc("rand_sync");
    end
    i_sync_n = 1'b1;
    $display("phase rand_sync checks=%0d", n_checks);

    // Reset in the middle of ILAS.
    i_sync_n = 1'b0;
    for (int c = 0; c < 6; c++) cyc("pre_rst");
    i_sync_n = 1'b1;
    for (int c = 0; c < 4 * FK && !(m_state == 1 && m_n == 40); c++) cyc("to_mid_ilas");
    chk("mid_ilas", 32'(o_state), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_mid_hold", 32'(outs()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst");
    chk("post_rst_cgs", 32'(o_data), 32'hBC);
    run_to_data("post_rst_ilas", 8 * FK);
    chk("post_rst_uflow", 32'(o_underflow), 32'd0);
    $display("phase mid_reset checks=%0d", n_checks);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
